// File: rtl/lzx_shift_tx.sv
// Serial shift-out transmitter for a 74HC595-style receiver chain.
// A parallel word is accepted on LOAD/READY, shifted out on SER/SRCLK, then latched with RCLK.
module lzx_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 2,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RD,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LOAD,
  output logic             READY,
  output logic             SER,
  output logic             SRCLK,
  output logic             RCLK,
  output logic             DONE,
  output logic [1:0]       dbg_state
);

  // Handshake: a word is taken on a rising CLK edge where LOAD and READY are both 1.
  // READY is 1 only in IDLE; LOAD at any other time is ignored, never queued.

  localparam int BW = $clog2(WIDTH + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    phase, phase_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             ready_n, ser_n, srclk_n, rclk_n, done_n;

  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;
  logic             phase_last;

  // The current bit always sits at the outgoing end of shreg.
  always_comb begin
    first_bit = LSB_FIRST ? DATA[0] : DATA[WIDTH-1];
    shifted   = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
    next_bit  = LSB_FIRST ? shifted[0] : shifted[WIDTH-1];
  end

  assign phase_last = (phase == PH_LAST);
  assign dbg_state  = state;

  always_ff @(posedge CLK or negedge RD) begin
    if (!RD) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      READY   <= 1'b1;
      SER     <= 1'b0;
      SRCLK   <= 1'b0;
      RCLK    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      READY   <= ready_n;
      SER     <= ser_n;
      SRCLK   <= srclk_n;
      RCLK    <= rclk_n;
      DONE    <= done_n;
    end
  end

  // Output values are computed for the next state so every pin comes straight off a flop.
  always_comb begin
    state_n = state;
    phase_n = phase;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    ready_n = 1'b0;
    ser_n   = SER;
    srclk_n = 1'b0;
    rclk_n  = 1'b0;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        ready_n = 1'b1;
        ser_n   = 1'b0;
        phase_n = '0;
        bit_n   = '0;
        if (LOAD && READY) begin
          shreg_n = DATA;
          ser_n   = first_bit;
          ready_n = 1'b0;
          state_n = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (phase_last) begin
          phase_n = '0;
          srclk_n = 1'b1;
          state_n = SHIFT_HI;
        end else begin
          phase_n = phase + 1'b1;
        end
      end

      SHIFT_HI: begin
        srclk_n = 1'b1;
        if (phase_last) begin
          phase_n = '0;
          srclk_n = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            ser_n   = 1'b0;
            rclk_n  = 1'b1;
            state_n = LATCH;
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shreg_n = shifted;
            ser_n   = next_bit;
            state_n = SHIFT_LO;
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end

      LATCH: begin
        rclk_n = 1'b1;
        ser_n  = 1'b0;
        if (phase_last) begin
          phase_n = '0;
          rclk_n  = 1'b0;
          done_n  = 1'b1;
          ready_n = 1'b1;
          state_n = IDLE;
        end else begin
          phase_n = phase + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lzx_shift_tx.sv
// Bench for lzx_shift_tx: three instances (defaults, LSB-first, DIV=1/WIDTH=4) checked
// against hand-computed edge tables, a 74HC595 receiver model and a latch scoreboard.
module tb_lzx_shift_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic [7:0] data_a, data_b;
  logic [3:0] data_c;
  logic       load_a, load_b, load_c;
  logic       ready_a, ser_a, srclk_a, rclk_a, done_a;
  logic       ready_b, ser_b, srclk_b, rclk_b, done_b;
  logic       ready_c, ser_c, srclk_c, rclk_c, done_c;
  logic [1:0] st_a, st_b, st_c;

  lzx_shift_tx #(.WIDTH(8), .DIV(2), .LSB_FIRST(1'b0)) dut_a (
    .CLK(clk), .RD(rst_n), .DATA(data_a), .LOAD(load_a), .READY(ready_a),
    .SER(ser_a), .SRCLK(srclk_a), .RCLK(rclk_a), .DONE(done_a), .dbg_state(st_a));

  lzx_shift_tx #(.WIDTH(8), .DIV(2), .LSB_FIRST(1'b1)) dut_b (
    .CLK(clk), .RD(rst_n), .DATA(data_b), .LOAD(load_b), .READY(ready_b),
    .SER(ser_b), .SRCLK(srclk_b), .RCLK(rclk_b), .DONE(done_b), .dbg_state(st_b));

  lzx_shift_tx #(.WIDTH(4), .DIV(1), .LSB_FIRST(1'b0)) dut_c (
    .CLK(clk), .RD(rst_n), .DATA(data_c), .LOAD(load_c), .READY(ready_c),
    .SER(ser_c), .SRCLK(srclk_c), .RCLK(rclk_c), .DONE(done_c), .dbg_state(st_c));

  // {READY, SER, SRCLK, RCLK, DONE}
  function automatic logic [4:0] sample(input int s);
    case (s)
      0:       return {ready_a, ser_a, srclk_a, rclk_a, done_a};
      1:       return {ready_b, ser_b, srclk_b, rclk_b, done_b};
      default: return {ready_c, ser_c, srclk_c, rclk_c, done_c};
    endcase
  endfunction

  // ---------------- checking ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- receiver model + scoreboard ----------------
  logic [7:0] exp_q[$];
  int         acc_q[$];
  logic [4:0] prev[3]     = '{5'b10000, 5'b10000, 5'b10000};
  logic [7:0] sr[3]       = '{8'h00, 8'h00, 8'h00};
  logic [7:0] lat[3]      = '{8'h00, 8'h00, 8'h00};
  int         done_cnt[3] = '{0, 0, 0};
  int         rclk_cnt[3] = '{0, 0, 0};
  int         viol = 0;
  logic [4:0] mon_v;
  logic [7:0] exp_word;

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      mon_v = sample(s);
      if (mon_v[2] && !prev[s][2]) sr[s] = {sr[s][6:0], mon_v[3]};
      if (mon_v[1] && !prev[s][1]) begin
        lat[s] = sr[s];
        rclk_cnt[s]++;
        if (s == 0) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL sb_latch: got %0h expected no latch", sr[0]);
          end else begin
            exp_word = exp_q.pop_front();
            check("sb_latch", {24'h0, sr[0]}, {24'h0, exp_word});
          end
        end
      end
      if (mon_v[0]) done_cnt[s]++;
      if (s == 0 && prev[s][4] && !mon_v[4]) acc_q.push_back(cyc);
      if ((mon_v[0] && mon_v[1]) || (mon_v[2] && mon_v[1])) viol++;
      prev[s] = mon_v;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int         sel;
    logic [7:0] data;
    int         edge_n;
    logic [4:0] exp_v;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int s, input logic [7:0] d, input int e, input logic [4:0] x);
    vec_t v;
    v.sel = s; v.data = d; v.edge_n = e; v.exp_v = x;
    vecs.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns just after the accept edge (edge 0).
  task automatic accept(input int s, input logic [7:0] d, input bit push);
    @(negedge clk);
    #1;
    case (s)
      0:       begin data_a = d;      load_a = 1'b1; end
      1:       begin data_b = d;      load_b = 1'b1; end
      default: begin data_c = d[3:0]; load_c = 1'b1; end
    endcase
    if (push) exp_q.push_back(d);
    @(posedge clk);
    #1;
    load_a = 1'b0;
    load_b = 1'b0;
    load_c = 1'b0;
  endtask

  task automatic wait_done(input int s, input int target);
    int t = 0;
    while (done_cnt[s] < target && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check($sformatf("done_wait_%0d", s), {31'h0, done_cnt[s] >= target}, 32'h1);
  endtask

  task automatic wait_acc(input int target);
    int t = 0;
    while (acc_q.size() < target && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("accept_wait", {31'h0, acc_q.size() >= target}, 32'h1);
  endtask

  // ---------------- main sequence ----------------
  int cur;
  int a0, d0, r0;

  initial begin
    rst_n  = 1'b0;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    data_a = '0;   data_b = '0;   data_c = '0;

    // Defaults, 8'hA5 MSB first: bits 1,0,1,0,0,1,0,1
    add(0, 8'hA5,  0, 5'b01000);
    add(0, 8'hA5,  1, 5'b01000);
    add(0, 8'hA5,  2, 5'b01100);
    add(0, 8'hA5,  3, 5'b01100);
    add(0, 8'hA5,  4, 5'b00000);
    add(0, 8'hA5,  6, 5'b00100);
    add(0, 8'hA5,  8, 5'b01000);
    add(0, 8'hA5, 10, 5'b01100);
    add(0, 8'hA5, 12, 5'b00000);
    add(0, 8'hA5, 16, 5'b00000);
    add(0, 8'hA5, 20, 5'b01000);
    add(0, 8'hA5, 28, 5'b01000);
    add(0, 8'hA5, 30, 5'b01100);
    add(0, 8'hA5, 31, 5'b01100);
    add(0, 8'hA5, 32, 5'b00010);
    add(0, 8'hA5, 33, 5'b00010);
    add(0, 8'hA5, 34, 5'b10001);
    add(0, 8'hA5, 35, 5'b10000);
    // LSB first, 8'h01: bits 1,0,0,0,0,0,0,0
    add(1, 8'h01,  0, 5'b01000);
    add(1, 8'h01,  2, 5'b01100);
    add(1, 8'h01,  4, 5'b00000);
    add(1, 8'h01, 32, 5'b00010);
    add(1, 8'h01, 34, 5'b10001);
    // DIV=1, WIDTH=4, 4'b1001
    add(2, 8'h09,  0, 5'b01000);
    add(2, 8'h09,  1, 5'b01100);
    add(2, 8'h09,  2, 5'b00000);
    add(2, 8'h09,  3, 5'b00100);
    add(2, 8'h09,  5, 5'b00100);
    add(2, 8'h09,  6, 5'b01000);
    add(2, 8'h09,  7, 5'b01100);
    add(2, 8'h09,  8, 5'b00010);
    add(2, 8'h09,  9, 5'b10001);
    add(2, 8'h09, 10, 5'b10000);

    #12;
    for (int s = 0; s < 3; s++) check($sformatf("reset_out_%0d", s), {27'h0, sample(s)}, 32'h10);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    cur = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].edge_n == 0) begin
        accept(vecs[i].sel, vecs[i].data, vecs[i].sel == 0);
        cur = 0;
      end else begin
        while (cur < vecs[i].edge_n) begin
          @(posedge clk);
          #1;
          cur++;
        end
      end
      check($sformatf("vec%0d_dut%0d_e%0d", i, vecs[i].sel, vecs[i].edge_n),
            {27'h0, sample(vecs[i].sel)}, {27'h0, vecs[i].exp_v});
    end
    step(3);
    check("a_serial",  {24'h0, sr[0]}, 32'hA5);
    check("b_serial",  {24'h0, sr[1]}, 32'h80);
    check("b_latch",   {24'h0, lat[1]}, 32'h80);
    check("c_serial",  {28'h0, sr[2][3:0]}, 32'h9);
    check("c_latch",   {28'h0, lat[2][3:0]}, 32'h9);
    check("a_dones",   done_cnt[0], 32'd1);
    check("b_dones",   done_cnt[1], 32'd1);
    check("c_dones",   done_cnt[2], 32'd1);

    // LOAD held high: 8'h3C then 8'hC3, 35 cycles apart
    a0 = acc_q.size();
    d0 = done_cnt[0];
    @(negedge clk);
    #1;
    data_a = 8'h3C;
    load_a = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    wait_acc(a0 + 1);
    data_a = 8'hC3;
    wait_acc(a0 + 2);
    load_a = 1'b0;
    check("b2b_period", acc_q[a0 + 1] - acc_q[a0], 32'd35);
    wait_done(0, d0 + 2);
    step(3);
    check("b2b_dones", done_cnt[0], d0 + 2);

    // LOAD with new data while busy is dropped
    a0 = acc_q.size();
    d0 = done_cnt[0];
    accept(0, 8'h5A, 1'b1);
    step(9);
    data_a = 8'hFF;
    load_a = 1'b1;
    step(1);
    load_a = 1'b0;
    wait_done(0, d0 + 1);
    step(40);
    check("busy_accepts", acc_q.size(), a0 + 1);
    check("busy_dones",   done_cnt[0], d0 + 1);

    // Reset at edge 13 aborts the word
    accept(0, 8'hF0, 1'b0);
    step(13);
    check("pre_abort", {27'h0, sample(0)}, 32'h08);
    r0 = rclk_cnt[0];
    d0 = done_cnt[0];
    rst_n = 1'b0;
    #1;
    check("abort_out", {27'h0, sample(0)}, 32'h10);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(45);
    check("abort_rclk",  rclk_cnt[0], r0);
    check("abort_done",  done_cnt[0], d0);
    check("abort_ready", {31'h0, ready_a}, 32'h1);
    accept(0, 8'hFF, 1'b1);
    wait_done(0, d0 + 1);
    step(3);
    check("after_abort_word", {24'h0, lat[0]}, 32'hFF);

    check("sb_empty",   exp_q.size(), 32'd0);
    check("invariants", viol, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
